bram_access_arbiter: RTL
========================

Name: bram_access_arbiter

Overview:
- Sequences and shares one simple-dual-port feature-map BRAM (port A write, port B read) between two write clients and two read clients in the CNN datapath.
- After reset, runs the BRAM reset/busy bring-up sequence.
- Then arbitrates each port independently with round-robin, and returns tagged read data after the BRAM read latency.
- Also resolves same-address write/read hazards.

Parameters:
AW, 4, BRAM address width
DW, 16, BRAM data width
RD_LATENCY, 1, cycles from bram_enb high to valid bram_doutb (1..4)
RST_CYCLES, 4, cycles bram_rstb is held high during bring-up (>=1)

Ports:
clk  in  1  single system clock, all logic rising-edge
rstb  in  1  synchronous active-low reset
wr_req  in  2  write request per client; held until granted
wr_addr  in  2*AW  packed addresses, client i at [i*AW +: AW]
wr_data  in  2*DW  packed write data, client i at [i*DW +: DW]
wr_gnt  out  2  combinational grant; transfer accepted at edge where wr_req[i]&wr_gnt[i]
rd_req  in  2  read request per client; held until granted
rd_addr  in  2*AW  packed read addresses
rd_gnt  out  2  combinational grant, same acceptance rule
rd_valid  out  2  one-cycle pulse: rd_data belongs to client i
rd_data  out  DW  read data (direct from bram_doutb), meaningful only with rd_valid
ready  out  1  high only in RUN
bram_ena, bram_wea  out  1, 1  BRAM port A enable / write enable
bram_addra, bram_dina  out  AW, DW  BRAM port A address / data
bram_rstb  out  1  BRAM port B reset, active-high
bram_enb, bram_addrb  out  1, AW  BRAM port B enable / address
bram_doutb  in  DW  BRAM read data
bram_rsta_busy, bram_rstb_busy  in  1, 1  BRAM reset-busy flags

Behaviour:
- rstb low at an edge: state=S_RST, counter=0, pointers=0, read-return pipeline flushed.
  - All outputs 0 except bram_rstb=1.
  - Applies mid-operation too: in-flight reads never produce rd_valid.
- FSM states:
  - S_RST: bram_rstb=1 for RST_CYCLES cycles after rstb release, then go to S_WAIT.
  - S_WAIT: bram_rstb=0. Stay while either busy flag is high, sampled at the edge; both low, go to S_RUN.
  - S_RUN: ready=1. Either busy flag high, go to S_WAIT; grants drop in that same cycle (gnt gated by registered busy sample).
- Grants (S_RUN only; 0 elsewhere):
  - Each port uses a 1-bit round-robin pointer, which names the preferred client.
  - Single requester is granted.
  - Both requesting: the preferred client is granted.
  - After each accepted transfer, the pointer moves to the other client.
  - At most one grant per port per cycle.
- Write path: on acceptance at edge k, bram_ena=bram_wea=1, bram_addra/dina = the winner's values during cycle k only.
- Read path: on acceptance at edge k, bram_enb=1, bram_addrb = the winner's address during cycle k.
  - rd_valid[winner]=1 in cycle k+RD_LATENCY, via a shift pipeline carrying the client id.
  - Back-to-back reads are fully pipelined; one read per cycle is sustained.
- Hazard: if a write is granted this cycle and the read winner's address equals the granted write address, rd_gnt=0 this cycle.
  - The read wins next cycle and returns the new data.
  - The read pointer does not move on the stalled cycle.
- Idle cycles: bram_ena/wea/enb = 0; addresses and data hold their last value.
- Independent ports: a write and a read to different addresses in the same cycle are both granted.

Test Plan:
- Bring-up: rstb low 3 cycles, then high; bram_busy flags high for 5 cycles after bram_rstb falls -> bram_rstb=1 for exactly 4 cycles; ready rises the cycle after both flags are low; no gnt before ready.
- Single write then read: client0 writes 16'hA5A5 to addr 2, accepted at edge k; client1 reads addr 2, accepted at k+2 -> bram_ena/wea high in cycle k; bram_enb high in cycle k+2; rd_valid=2'b10 with rd_data=A5A5 in cycle k+3.
- Round-robin: both read clients hold rd_req for 4 cycles at addrs 1/3 -> grants alternate 01,10,01,10; rd_valid returns in the same order, 1 cycle later each.
- Hazard: in the same cycle, write 16'h1234 to addr 5 and read addr 5 (old data 16'h0000) -> rd_gnt=0 that cycle, granted next cycle, rd_data=1234.
- Busy mid-run: assert bram_rstb_busy for 2 cycles while requests are pending -> ready drops, no grants, state S_WAIT; resumes when busy clears with pointers preserved.
- Reset mid-read: rstb low in the cycle after a read is accepted -> no rd_valid ever; all outputs 0 except bram_rstb=1; full bring-up repeats.

Source files
------------

// File: rtl/bram_access_arbiter.sv
// Shares one simple-dual-port BRAM between two write and two read clients:
// bring-up sequencing, per-port round-robin, tagged read return, RAW hazard stall.
module bram_access_arbiter #(
   parameter int AW         = 4,
   parameter int DW         = 16,
   parameter int RD_LATENCY = 1,
   parameter int RST_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rstb,
   input  logic [1:0]      wr_req,
   input  logic [2*AW-1:0] wr_addr,
   input  logic [2*DW-1:0] wr_data,
   output logic [1:0]      wr_gnt,
   input  logic [1:0]      rd_req,
   input  logic [2*AW-1:0] rd_addr,
   output logic [1:0]      rd_gnt,
   output logic [1:0]      rd_valid,
   output logic [DW-1:0]   rd_data,
   output logic            ready,
   output logic            bram_ena,
   output logic            bram_wea,
   output logic [AW-1:0]   bram_addra,
   output logic [DW-1:0]   bram_dina,
   output logic            bram_rstb,
   output logic            bram_enb,
   output logic [AW-1:0]   bram_addrb,
   input  logic [DW-1:0]   bram_doutb,
   input  logic            bram_rsta_busy,
   input  logic            bram_rstb_busy
);

   localparam int CW = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {S_RST, S_WAIT, S_RUN} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [1:0]            busy_q;
   logic                  wr_ptr, rd_ptr;
   logic                  ready_q, bram_rstb_q;
   logic [AW-1:0]         addra_q, addrb_q;
   logic [DW-1:0]         dina_q;
   logic [RD_LATENCY-1:0] pipe_v, pipe_id;

   logic          run_ok, wr_any, rd_any, wr_win, rd_win, hazard;
   logic [AW-1:0] wr_sel_addr, rd_sel_addr;
   logic [DW-1:0] wr_sel_data;

   always_comb begin
      run_ok      = (state == S_RUN) && (busy_q == 2'b00);
      wr_win      = (wr_req == 2'b11) ? wr_ptr : wr_req[1];
      rd_win      = (rd_req == 2'b11) ? rd_ptr : rd_req[1];
      wr_sel_addr = wr_win ? wr_addr[2*AW-1:AW] : wr_addr[AW-1:0];
      wr_sel_data = wr_win ? wr_data[2*DW-1:DW] : wr_data[DW-1:0];
      rd_sel_addr = rd_win ? rd_addr[2*AW-1:AW] : rd_addr[AW-1:0];
      wr_any      = run_ok && (wr_req != 2'b00);
      // A read of the address being written this cycle waits one cycle so it sees the new data
      hazard      = wr_any && (rd_sel_addr == wr_sel_addr);
      rd_any      = run_ok && (rd_req != 2'b00) && !hazard;

      wr_gnt      = wr_any ? (wr_win ? 2'b10 : 2'b01) : 2'b00;
      rd_gnt      = rd_any ? (rd_win ? 2'b10 : 2'b01) : 2'b00;
      bram_ena    = wr_any;
      bram_wea    = wr_any;
      bram_addra  = wr_any ? wr_sel_addr : addra_q;
      bram_dina   = wr_any ? wr_sel_data : dina_q;
      bram_enb    = rd_any;
      bram_addrb  = rd_any ? rd_sel_addr : addrb_q;
      ready       = ready_q;
      bram_rstb   = bram_rstb_q;
      rd_data     = bram_doutb;
      // Gating by rstb keeps a read already in flight from surfacing while reset is applied
      rd_valid    = (pipe_v[RD_LATENCY-1] && rstb) ?
                    (pipe_id[RD_LATENCY-1] ? 2'b10 : 2'b01) : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state       <= S_RST;
         cnt         <= '0;
         busy_q      <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         ready_q     <= 1'b0;
         bram_rstb_q <= 1'b1;
         addra_q     <= '0;
         addrb_q     <= '0;
         dina_q      <= '0;
         pipe_v      <= '0;
         pipe_id     <= '0;
      end else begin
         busy_q <= {bram_rstb_busy, bram_rsta_busy};
         case (state)
            S_RST: begin
               if (cnt == CW'(RST_CYCLES - 1)) begin
                  state       <= S_WAIT;
                  bram_rstb_q <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_WAIT: begin
               if (!bram_rsta_busy && !bram_rstb_busy) begin
                  state   <= S_RUN;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               if (bram_rsta_busy || bram_rstb_busy) begin
                  state   <= S_WAIT;
                  ready_q <= 1'b0;
               end
            end
         endcase

         if (wr_any) begin
            wr_ptr  <= ~wr_win;
            addra_q <= wr_sel_addr;
            dina_q  <= wr_sel_data;
         end
         if (rd_any) begin
            rd_ptr  <= ~rd_win;
            addrb_q <= rd_sel_addr;
         end

         pipe_v[0]  <= rd_any;
         pipe_id[0] <= rd_win;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_id[i] <= pipe_id[i-1];
         end
      end
   end

endmodule
